// File: rtl/vga_rx_pkg.sv
// Shared timing constants and FSM encoding for the VGA sync receiver.
package vga_rx_pkg;

  localparam int VGA_H_DISPLAY   = 640;
  localparam int VGA_H_FRONT     = 16;
  localparam int VGA_H_SYNC      = 96;
  localparam int VGA_H_BACK      = 48;
  localparam int VGA_V_DISPLAY   = 480;
  localparam int VGA_V_FRONT     = 10;
  localparam int VGA_V_SYNC      = 2;
  localparam int VGA_V_BACK      = 33;
  localparam bit VGA_SYNC_ACTIVE = 1'b0;
  localparam int VGA_LOCK_FRAMES = 2;

  localparam int VGA_H_TOTAL = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;
  localparam int VGA_V_TOTAL = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // Column / line at which a correctly timed sync assertion edge is sampled
  localparam int VGA_H_EDGE = VGA_H_DISPLAY + VGA_H_FRONT;
  localparam int VGA_V_EDGE = VGA_V_DISPLAY + VGA_V_FRONT;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_H_ALIGN = 2'd1,
    ST_V_ALIGN = 2'd2,
    ST_LOCKED  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Assertion-edge detector for one sync line: remembers the level seen on the
// previous pixel tick and flags the tick where the line becomes active.
module vga_sync_edge #(
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic p_tick,
  input  logic sync,
  output logic sync_edge
);

  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_reg <= ~SYNC_ACTIVE;
    end else if (p_tick) begin
      prev_reg <= sync;
    end
  end

  assign sync_edge = p_tick && (sync == SYNC_ACTIVE) && (prev_reg != SYNC_ACTIVE);

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive front-end: rebuilds pixel coordinates from hsync/vsync, checks
// edge timing, locks after clean frames and captures visible pixels.
// Optional statistics (line_len, err_count) are built when VGA_RX_STATS_EN is defined.
module vga_sync_receiver
  import vga_rx_pkg::*;
#(
  parameter int H_DISPLAY   = VGA_H_DISPLAY,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_SYNC      = VGA_H_SYNC,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int V_DISPLAY   = VGA_V_DISPLAY,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_SYNC      = VGA_V_SYNC,
  parameter int V_BACK      = VGA_V_BACK,
  parameter bit SYNC_ACTIVE = VGA_SYNC_ACTIVE,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p_tick,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [2:0] rgb_in,
  output logic [9:0] rx_x,
  output logic [9:0] rx_y,
  output logic [2:0] rx_rgb,
  output logic       pixel_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       h_err,
  output logic       v_err,
  output logic [9:0] line_len,
  output logic [7:0] err_count
);

  localparam logic [9:0] H_LAST = 10'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_EDGE = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] V_EDGE = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [3:0] GOOD_TARGET = 4'(LOCK_FRAMES);

  rx_state_t  state_reg, state_next;
  logic [9:0] h_cnt_reg, v_cnt_reg, rx_x_reg, rx_y_reg;
  logic [2:0] rx_rgb_reg;
  logic [3:0] good_reg;
  logic       err_seen_reg, pixel_valid_reg, frame_start_reg, h_err_reg, v_err_reg;
  logic       hs_edge, vs_edge, h_mis, v_mis, h_wrap, err_en, is_locked;
  logic [9:0] v_base;
  logic [1:0] sync_bus, edge_bus;

  assign sync_bus = {vsync, hsync};
  for (genvar gi = 0; gi < 2; gi++) begin : g_edge
    vga_sync_edge #(.SYNC_ACTIVE(SYNC_ACTIVE)) u_edge (
      .clk       (clk),
      .reset     (reset),
      .p_tick    (p_tick),
      .sync      (sync_bus[gi]),
      .sync_edge (edge_bus[gi])
    );
  end
  assign hs_edge = edge_bus[0];
  assign vs_edge = edge_bus[1];

  assign h_mis  = hs_edge && (h_cnt_reg != H_EDGE);
  assign v_mis  = vs_edge && ((h_cnt_reg != 10'd0) || (v_cnt_reg != V_EDGE));
  assign h_wrap = (h_cnt_reg == H_LAST);
  // A vsync edge relabels the current line before any wrap increment applies
  assign v_base = vs_edge ? V_EDGE : v_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (p_tick) begin
      if (hs_edge)     h_cnt_reg <= H_EDGE + 10'd1;
      else if (h_wrap) h_cnt_reg <= '0;
      else             h_cnt_reg <= h_cnt_reg + 10'd1;
      if (h_wrap && !hs_edge) v_cnt_reg <= (v_base == V_LAST) ? '0 : v_base + 10'd1;
      else                    v_cnt_reg <= v_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_SEARCH;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_SEARCH:  if (hs_edge) state_next = ST_H_ALIGN;
      ST_H_ALIGN: if (vs_edge) state_next = ST_V_ALIGN;
      ST_V_ALIGN: if (good_reg == GOOD_TARGET) state_next = ST_LOCKED;
      ST_LOCKED:  if (h_mis || v_mis) state_next = ST_SEARCH;
      default:    state_next = ST_SEARCH;
    endcase
  end

  always_comb begin
    is_locked = (state_reg == ST_LOCKED);
    err_en    = (state_reg == ST_V_ALIGN) || (state_reg == ST_LOCKED);
  end

  // A frame only counts toward lock if no error occurred since the previous vsync
  always_ff @(posedge clk) begin
    if (reset) begin
      good_reg     <= '0;
      err_seen_reg <= 1'b0;
    end else if (state_reg == ST_H_ALIGN && vs_edge) begin
      good_reg     <= '0;
      err_seen_reg <= 1'b0;
    end else if (state_reg == ST_V_ALIGN) begin
      if (h_mis || v_mis) begin
        good_reg     <= '0;
        err_seen_reg <= !vs_edge;
      end else if (vs_edge) begin
        if (err_seen_reg) err_seen_reg <= 1'b0;
        else              good_reg     <= good_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_x_reg        <= '0;
      rx_y_reg        <= '0;
      rx_rgb_reg      <= '0;
      pixel_valid_reg <= 1'b0;
      frame_start_reg <= 1'b0;
      h_err_reg       <= 1'b0;
      v_err_reg       <= 1'b0;
    end else begin
      pixel_valid_reg <= 1'b0;
      frame_start_reg <= 1'b0;
      h_err_reg       <= h_mis && err_en;
      v_err_reg       <= v_mis && err_en;
      if (is_locked && p_tick && (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS)) begin
        rx_x_reg        <= h_cnt_reg;
        rx_y_reg        <= v_cnt_reg;
        rx_rgb_reg      <= rgb_in;
        pixel_valid_reg <= 1'b1;
        frame_start_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
      end
    end
  end

  assign rx_x        = rx_x_reg;
  assign rx_y        = rx_y_reg;
  assign rx_rgb      = rx_rgb_reg;
  assign pixel_valid = pixel_valid_reg;
  assign frame_start = frame_start_reg;
  assign locked      = is_locked;
  assign h_err       = h_err_reg;
  assign v_err       = v_err_reg;

`ifdef VGA_RX_STATS_EN
  logic [9:0] tick_cnt_reg, line_len_reg;
  logic [7:0] err_count_reg;
  logic [8:0] err_sum;

  assign err_sum = {1'b0, err_count_reg} + 9'(h_err_reg) + 9'(v_err_reg);

  // tick_cnt holds the number of ticks elapsed since the last hsync edge
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_reg  <= '0;
      line_len_reg  <= '0;
      err_count_reg <= '0;
    end else begin
      if (p_tick) begin
        if (hs_edge) begin
          line_len_reg <= tick_cnt_reg;
          tick_cnt_reg <= 10'd1;
        end else if (tick_cnt_reg != 10'h3FF) begin
          tick_cnt_reg <= tick_cnt_reg + 10'd1;
        end
      end
      err_count_reg <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end
  end

  assign line_len  = line_len_reg;
  assign err_count = err_count_reg;
`else
  assign line_len  = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench: reduced-size VGA timing, phase table plus capture scoreboard.
module tb_vga_sync_receiver;

  localparam int HD = 8, HF = 2, HS = 3, HB = 3;
  localparam int VD = 4, VF = 2, VS = 2, VB = 2;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int HE = HD + HF;
  localparam int VE = VD + VF;
  localparam int LF = 2;
  localparam bit SA = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       p_tick = 1'b0;
  logic       hsync = !SA;
  logic       vsync = !SA;
  logic [2:0] rgb_in = 3'd0;
  logic [9:0] rx_x, rx_y, line_len;
  logic [2:0] rx_rgb;
  logic       pixel_valid, frame_start, locked, h_err, v_err;
  logic [7:0] err_count;

  vga_sync_receiver #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(SA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
    .rgb_in(rgb_in), .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb),
    .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
    .h_err(h_err), .v_err(v_err), .line_len(line_len), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       x;
    int       y;
    logic [2:0] rgb;
    bit       fs;
  } cap_t;

  // fault: 0 none, 1 hsync of line 1 delayed 3 pixels, 2 reset pulse mid-line 2
  typedef struct {
    bit         pat;
    logic [2:0] rgb;
    int         frames;
    int         fault;
    bit         exp_locked;
    int         exp_herr;
    int         exp_valid;
    int         exp_errcnt;
  } phase_t;

  cap_t   sb_q[$];
  phase_t tbl[7];
  int checks = 0, errors = 0;
  int gx = 0, gy = 0, clean_vs = 0;
  bit exp_locked = 1'b0;
  int valid_n, herr_n, verr_n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    cap_t e;
    if (h_err) herr_n++;
    if (v_err) verr_n++;
    if (pixel_valid) begin
      valid_n++;
      check("sb_nonempty", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("rx_x", int'(rx_x), e.x);
        check("rx_y", int'(rx_y), e.y);
        check("rx_rgb", int'(rx_rgb), int'(e.rgb));
        check("frame_start", int'(frame_start), int'(e.fs));
      end
    end else begin
      check("frame_start_alone", int'(frame_start), 0);
    end
  endtask

  task automatic one_clk(input bit tick);
    p_tick = tick;
    @(posedge clk);
    #1;
    sample();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, int'({rx_x, rx_y, rx_rgb, pixel_valid, frame_start, locked, h_err, v_err}), 0);
    check({name, "_stats"}, int'({line_len, err_count}), 0);
  endtask

  task automatic gen_tick(input phase_t ph, input bit fault_line);
    int lo;
    bit ha, va;
    logic [2:0] c;
    lo = fault_line ? HE + 3 : HE;
    ha = (gx >= lo) && (gx < lo + HS);
    va = (gy >= VE) && (gy < VE + VS);
    hsync = ha ? SA : !SA;
    vsync = va ? SA : !SA;
    c = ph.pat ? 3'(gx ^ (gy * 3)) : ph.rgb;
    rgb_in = c;
    if (exp_locked && gx < HD && gy < VD)
      sb_q.push_back('{gx, gy, c, (gx == 0 && gy == 0)});
    if (gx == 0 && gy == VE && clean_vs < 15) clean_vs++;
    if (fault_line && gx == HE + 3) clean_vs = 0;
    exp_locked = (clean_vs >= LF + 1);
    one_clk(1'b1);
    one_clk(1'b0);
    one_clk(1'b0);
    one_clk(1'b0);
    if (gx == HT - 1) begin
      gx = 0;
      gy = (gy == VT - 1) ? 0 : gy + 1;
    end else begin
      gx++;
    end
  endtask

  initial begin
    int exp_ll, exp_ec;
    tbl[0] = '{pat: 1'b1, rgb: 3'b000, frames: 3, fault: 0, exp_locked: 1'b1, exp_herr: 0, exp_valid: 0,  exp_errcnt: 0};
    tbl[1] = '{pat: 1'b0, rgb: 3'b101, frames: 1, fault: 0, exp_locked: 1'b1, exp_herr: 0, exp_valid: 32, exp_errcnt: 0};
    tbl[2] = '{pat: 1'b1, rgb: 3'b000, frames: 1, fault: 0, exp_locked: 1'b1, exp_herr: 0, exp_valid: 32, exp_errcnt: 0};
    tbl[3] = '{pat: 1'b1, rgb: 3'b000, frames: 1, fault: 1, exp_locked: 1'b0, exp_herr: 1, exp_valid: 16, exp_errcnt: 1};
    tbl[4] = '{pat: 1'b0, rgb: 3'b011, frames: 3, fault: 0, exp_locked: 1'b1, exp_herr: 0, exp_valid: 32, exp_errcnt: 1};
    tbl[5] = '{pat: 1'b1, rgb: 3'b000, frames: 1, fault: 2, exp_locked: 1'b0, exp_herr: 0, exp_valid: 19, exp_errcnt: 0};
    tbl[6] = '{pat: 1'b1, rgb: 3'b000, frames: 3, fault: 0, exp_locked: 1'b1, exp_herr: 0, exp_valid: 32, exp_errcnt: 0};

    valid_n = 0; herr_n = 0; verr_n = 0;
    reset = 1'b1;
    one_clk(1'b0);
    one_clk(1'b0);
    one_clk(1'b0);
    check_reset_outputs("reset_state");
    reset = 1'b0;

    for (int p = 0; p < 7; p++) begin
      valid_n = 0; herr_n = 0; verr_n = 0;
      for (int f = 0; f < tbl[p].frames; f++) begin
        for (int t = 0; t < HT * VT; t++) begin
          if (tbl[p].fault == 2 && f == 0 && gy == 2 && gx == 3) begin
            check("locked_before_reset", int'(locked), 1);
            reset = 1'b1;
            one_clk(1'b0);
            check_reset_outputs("midline_reset");
            reset = 1'b0;
            clean_vs = 0;
            exp_locked = 1'b0;
          end
          gen_tick(tbl[p], (tbl[p].fault == 1 && f == 0 && gy == 1));
        end
      end
`ifdef VGA_RX_STATS_EN
      exp_ll = HT;
      exp_ec = tbl[p].exp_errcnt;
`else
      exp_ll = 0;
      exp_ec = 0;
`endif
      $display("phase %0d: valid=%0d herr=%0d verr=%0d locked=%0b line_len=%0d err_count=%0d",
               p, valid_n, herr_n, verr_n, locked, line_len, err_count);
      check($sformatf("locked_p%0d", p), int'(locked), int'(tbl[p].exp_locked));
      check($sformatf("h_err_count_p%0d", p), herr_n, tbl[p].exp_herr);
      check($sformatf("v_err_count_p%0d", p), verr_n, 0);
      check($sformatf("valid_count_p%0d", p), valid_n, tbl[p].exp_valid);
      check($sformatf("sb_drained_p%0d", p), sb_q.size(), 0);
      check($sformatf("line_len_p%0d", p), int'(line_len), exp_ll);
      check($sformatf("err_count_p%0d", p), int'(err_count), exp_ec);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
